// File: rtl/offnariscv_pkg.sv
// Shared type definitions for the offnariscv core slice.
// Holds the L1I flush sequencer state encoding used by l1i_flush_sequencer.
package offnariscv_pkg;

  typedef enum logic [1:0] {
    FLUSH_IDLE,
    FLUSH_DRAIN,
    FLUSH_WALK,
    FLUSH_DONE
  } l1i_flush_state_t;

endpackage

// File: rtl/l1i_flush_sequencer.sv
// FENCE.I flush sequencer: drains the IFU, then invalidates every L1I directory index.
// Optional statistics ports are enabled by defining L1I_FLUSH_STATS_EN.
module l1i_flush_sequencer
  import offnariscv_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_req_valid,
  output logic                   flush_req_ready,
  output logic                   ifu_stall,
  input  logic                   ifu_idle,
  output logic                   dir_inv_valid,
  input  logic                   dir_inv_ready,
  output logic [INDEX_WIDTH-1:0] dir_inv_index,
  output logic                   busy,
  output logic                   flush_done
`ifdef L1I_FLUSH_STATS_EN
  ,
  output logic [31:0]            flush_count,
  output logic [15:0]            flush_cycles
`endif
);

  localparam logic [INDEX_WIDTH-1:0] IDX_LAST = '1;
  localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = INDEX_WIDTH'(1);

  l1i_flush_state_t       state_q, state_d;
  logic [INDEX_WIDTH-1:0] idx_q, idx_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      FLUSH_IDLE: begin
        if (flush_req_valid) state_d = FLUSH_DRAIN;
      end
      FLUSH_DRAIN: begin
        if (ifu_idle) begin
          state_d = FLUSH_WALK;
          idx_d   = '0;
        end
      end
      FLUSH_WALK: begin
        // Index only advances on a handshake, so valid/index stay stable while stalled.
        if (dir_inv_ready) begin
          if (idx_q == IDX_LAST) state_d = FLUSH_DONE;
          else                   idx_d   = idx_q + IDX_ONE;
        end
      end
      FLUSH_DONE: begin
        state_d = FLUSH_IDLE;
        idx_d   = '0;
      end
      default: begin
        state_d = FLUSH_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FLUSH_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Outputs decode registered state only; rst forces them low while asserted.
  always_comb begin
    flush_req_ready = 1'b0;
    ifu_stall       = 1'b0;
    dir_inv_valid   = 1'b0;
    dir_inv_index   = '0;
    busy            = 1'b0;
    flush_done      = 1'b0;
    if (!rst) begin
      unique case (state_q)
        FLUSH_IDLE: flush_req_ready = 1'b1;
        FLUSH_DRAIN: begin
          ifu_stall = 1'b1;
          busy      = 1'b1;
        end
        FLUSH_WALK: begin
          ifu_stall     = 1'b1;
          busy          = 1'b1;
          dir_inv_valid = 1'b1;
          dir_inv_index = idx_q;
        end
        FLUSH_DONE: begin
          ifu_stall  = 1'b1;
          busy       = 1'b1;
          flush_done = 1'b1;
        end
        default: flush_req_ready = 1'b0;
      endcase
    end
  end

`ifdef L1I_FLUSH_STATS_EN
  localparam int unsigned CNT_W = 32;
  localparam int unsigned CYC_W = 16;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CYC_W-1:0] run_q, run_d;
  logic [CYC_W-1:0] last_q, last_d;
  logic [CYC_W-1:0] run_inc;

  // run_q counts from the accept cycle (as 1); DONE adds its own cycle when latching.
  always_comb begin
    run_inc = (run_q == '1) ? run_q : run_q + CYC_ONE;
    count_d = count_q;
    run_d   = run_q;
    last_d  = last_q;
    unique case (state_q)
      FLUSH_IDLE: begin
        if (flush_req_valid) run_d = CYC_ONE;
      end
      FLUSH_DRAIN, FLUSH_WALK: run_d = run_inc;
      FLUSH_DONE: begin
        last_d  = run_inc;
        count_d = count_q + CNT_ONE;
      end
      default: run_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      run_q   <= '0;
      last_q  <= '0;
    end else begin
      count_q <= count_d;
      run_q   <= run_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    flush_count  = rst ? '0 : count_q;
    flush_cycles = rst ? '0 : last_q;
  end
`endif

endmodule

// File: tb/tb_l1i_flush_sequencer.sv
// Self-checking bench for l1i_flush_sequencer (INDEX_WIDTH=2), directed steps plus random traffic.
// Define L1I_FLUSH_STATS_EN to also check the statistics ports.
module tb_l1i_flush_sequencer;

  localparam int unsigned IW = 2;
  localparam int unsigned N  = 1 << IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush_req_valid;
  logic          flush_req_ready;
  logic          ifu_stall;
  logic          ifu_idle;
  logic          dir_inv_valid;
  logic          dir_inv_ready;
  logic [IW-1:0] dir_inv_index;
  logic          busy;
  logic          flush_done;
`ifdef L1I_FLUSH_STATS_EN
  logic [31:0]   flush_count;
  logic [15:0]   flush_cycles;
`endif

  always #5 clk = ~clk;

  l1i_flush_sequencer #(.INDEX_WIDTH(IW)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_req_valid (flush_req_valid),
    .flush_req_ready (flush_req_ready),
    .ifu_stall       (ifu_stall),
    .ifu_idle        (ifu_idle),
    .dir_inv_valid   (dir_inv_valid),
    .dir_inv_ready   (dir_inv_ready),
    .dir_inv_index   (dir_inv_index),
    .busy            (busy),
    .flush_done      (flush_done)
`ifdef L1I_FLUSH_STATS_EN
    ,
    .flush_count     (flush_count),
    .flush_cycles    (flush_cycles)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0=idle 1=drain 2=walk 3=done; the walk is a queue of pending indices.
  int          m_mode = 0;
  int          m_q[$];
  int          hs[$];
  int unsigned m_count = 0;
  int          m_cyc = 0;
  int          m_last = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic v, input logic idl, input logic rdy, input logic r);
    if (r) begin
      m_mode = 0;
      m_q.delete();
      m_count = 0;
      m_cyc = 0;
      m_last = 0;
    end else begin
      case (m_mode)
        0: if (v) begin m_mode = 1; m_cyc = 1; end
        1: begin
          m_cyc++;
          if (idl) begin
            m_mode = 2;
            m_q.delete();
            for (int i = 0; i < N; i++) m_q.push_back(i);
          end
        end
        2: begin
          m_cyc++;
          if (rdy) begin
            void'(m_q.pop_front());
            if (m_q.size() == 0) m_mode = 3;
          end
        end
        default: begin
          m_mode = 0;
          m_count++;
          m_last = (m_cyc + 1 > 65535) ? 65535 : m_cyc + 1;
        end
      endcase
    end
  endtask

  task automatic check_outputs(input logic r);
    chk("ready", flush_req_ready, !r && m_mode == 0);
    chk("stall", ifu_stall,       !r && m_mode != 0);
    chk("busy",  busy,            !r && m_mode != 0);
    chk("valid", dir_inv_valid,   !r && m_mode == 2);
    chk("done",  flush_done,      !r && m_mode == 3);
    if (!r && m_mode == 2) chk("index", dir_inv_index, m_q[0]);
`ifdef L1I_FLUSH_STATS_EN
    chk("count",  flush_count,  m_count);
    chk("cycles", flush_cycles, m_last);
`endif
  endtask

  task automatic step(input logic v, input logic idl, input logic rdy, input logic r);
    flush_req_valid = v;
    ifu_idle        = idl;
    dir_inv_ready   = rdy;
    rst             = r;
    if (!r && dir_inv_valid && rdy) hs.push_back(int'(dir_inv_index));
    @(posedge clk);
    model_update(v, idl, rdy, r);
    #1;
    check_outputs(r);
  endtask

  task automatic chk_hs(input string tag);
    chk({tag, "_hs_len"}, hs.size(), N);
    for (int i = 0; i < N && i < hs.size(); i++) chk({tag, "_hs_idx"}, hs[i], i);
    hs.delete();
  endtask

  initial begin
    int  k;
    int  pend;
    logic r, idl, rdy, acc;
    flush_req_valid = 1'b0;
    ifu_idle        = 1'b1;
    dir_inv_ready   = 1'b1;
    rst             = 1'b1;

    // reset
    step(0, 1, 1, 1);
    step(1, 1, 1, 1);
    chk("rst_ready_low", flush_req_ready, 0);
    step(0, 1, 1, 0);
    chk("post_rst_ready", flush_req_ready, 1);
    hs.delete();

    // test 1: ideal latency
    step(1, 1, 1, 0);
    k = 1;
    while (!flush_done && k < 50) begin
      step(0, 1, 1, 0);
      k++;
      if (k >= 2 && k <= N + 1) chk("t1_index", dir_inv_index, k - 2);
    end
    chk("t1_done_cycle", k, N + 2);
    step(0, 1, 1, 0);
    chk("t1_ready_back", flush_req_ready, 1);
`ifdef L1I_FLUSH_STATS_EN
    chk("t1_cycles", flush_cycles, N + 3);
    chk("t1_count", flush_count, 1);
`endif
    chk_hs("t1");

    // test 2: IFU busy for 5 cycles after accept
    step(1, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 1, 0);
      chk("t2_no_valid", dir_inv_valid, 0);
    end
    step(0, 1, 1, 0);
    chk("t2_walk_start", dir_inv_valid, 1);
    chk("t2_idx0", dir_inv_index, 0);
    for (int i = 0; i < 20 && !flush_done; i++) step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    chk_hs("t2");

    // test 3: directory ready pattern 1,0,0
    step(1, 1, 0, 0);
    k = 0;
    for (int i = 0; i < 60 && !flush_done; i++) begin
      step(0, 1, (k % 3) == 0, 0);
      if (m_mode == 2) k++;
    end
    chk("t3_done_seen", flush_done, 1);
    step(0, 1, 1, 0);
    chk_hs("t3");

    // test 4: request held high through a flush
    step(1, 1, 1, 0);
    for (int i = 0; i < 20 && !flush_done; i++) step(1, 1, 1, 0);
    chk("t4_done_seen", flush_done, 1);
    step(1, 1, 1, 0);
    chk("t4_ready_after_done", flush_req_ready, 1);
    step(1, 1, 1, 0);
    chk("t4_reaccept", busy, 1);
    step(0, 1, 1, 0);
    chk("t4_idx0", dir_inv_index, 0);
    for (int i = 0; i < 20 && !flush_done; i++) step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    hs.delete();

    // test 5: reset while walking at index 2
    step(1, 1, 1, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    chk("t5_at_idx2", dir_inv_index, 2);
    step(0, 1, 1, 1);
    chk("t5_rst_valid", dir_inv_valid, 0);
    chk("t5_rst_stall", ifu_stall, 0);
    step(0, 1, 1, 0);
    chk("t5_ready", flush_req_ready, 1);
    hs.delete();
    step(1, 1, 1, 0);
    for (int i = 0; i < 20 && !flush_done; i++) step(0, 1, 1, 0);
    step(0, 1, 1, 0);
    chk_hs("t5");

    // random traffic against the model
    pend = 0;
    for (int i = 0; i < 400; i++) begin
      if (pend == 0 && $urandom_range(3) == 0) pend = 1;
      idl = ($urandom_range(9) < 7);
      rdy = ($urandom_range(1) == 1);
      r   = ($urandom_range(99) == 0);
      acc = (pend != 0) && flush_req_ready;
      step(pend != 0, idl, rdy, r);
      if (acc || r) pend = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
